// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and bit-timing constants.
package uart_pkg;

  // Clock cycles per bit = prescale * OVERSAMPLE; the start bit is checked HALF_BIT*prescale in.
  localparam int OVERSAMPLE = 8;
  localparam int HALF_BIT   = 4;

  // 16-bit prescale times 8 needs 19 bits of bit-timer range.
  localparam int TIMER_W = 16 + 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high while the count is zero, and the count parks at zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Count down towards zero; a load restarts the interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (1 start, DATA_WIDTH data LSB first, 1 stop) delivering words on an AXI4-Stream master.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error
);

  localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic                  rxd_reg;
  logic [15:0]           prescale_lat;
  logic [15:0]           p_eff;
  logic [3:0]            bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tmr_load;
  logic [TIMER_W-1:0]    tmr_val;
  logic [TIMER_W-1:0]    half_reload;
  logic [TIMER_W-1:0]    bit_reload;
  logic                  tc;
  logic                  latch_pre;
  logic                  shift_en;
  logic                  deliver;
  logic                  ferr_evt;

  // A prescale of zero behaves as one.
  assign p_eff       = (prescale == 16'd0) ? 16'd1 : prescale;
  // The timer reaches zero load_val cycles after the load, so reload with interval - 1.
  assign half_reload = TIMER_W'({p_eff, 2'b00}) - TIMER_W'(1);
  assign bit_reload  = TIMER_W'({prescale_lat, 3'b000}) - TIMER_W'(1);

  uart_bit_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // State register and single-stage input synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rxd_reg <= 1'b1;
    end else begin
      state   <= state_nxt;
      rxd_reg <= rxd;
    end
  end

  // Next-state logic and per-cycle strobes for the timer, shifter and output register.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = bit_reload;
    latch_pre = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    ferr_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_reg) begin
          state_nxt = START;
          tmr_load  = 1'b1;
          tmr_val   = half_reload;
          latch_pre = 1'b1;
        end
      end
      START: begin
        if (tc) begin
          if (!rxd_reg) begin
            state_nxt = DATA;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tc) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (tc) begin
          if (rxd_reg) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_evt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_reg) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame bookkeeping: prescale snapshot and data-bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_lat <= 16'd0;
      bit_idx      <= 4'd0;
    end else begin
      if (latch_pre) begin
        prescale_lat <= p_eff;
      end
      if (shift_en) begin
        bit_idx <= bit_idx + 4'd1;
      end else if (state != DATA) begin
        bit_idx <= 4'd0;
      end
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= {rxd_reg, shreg[DATA_WIDTH-1:1]};
    end
  end

  // AXI-Stream output register with overrun and frame-error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
    end else begin
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= ferr_evt;
      if (deliver) begin
        m_axis_tdata     <= shreg;
        m_axis_tvalid    <= 1'b1;
        rx_overrun_error <= m_axis_tvalid && !m_axis_tready;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: frame-level timing model plus directed literal checks.
module tb_uart_rx_axis;

  localparam int DW   = 8;
  localparam int MAXC = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic [15:0]   prescale = 16'd1;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          busy;
  logic          ovr;
  logic          ferr;

  uart_rx_axis #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .rxd              (rxd),
    .prescale         (prescale),
    .m_axis_tdata     (tdata),
    .m_axis_tvalid    (tvalid),
    .m_axis_tready    (tready),
    .rx_busy          (busy),
    .rx_overrun_error (ovr),
    .rx_frame_error   (ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle events, filled in by the stimulus tasks from frame timing.
  bit            exp_busy [MAXC];
  bit            del_v    [MAXC];
  logic [DW-1:0] del_d    [MAXC];
  bit            ferr_a   [MAXC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one frame starting this cycle and record what it must produce.
  task automatic send_frame(input logic [DW-1:0] data, input bit stop, input int pre,
                            input int extra_low, output int d);
    int p, b, s;
    p = (pre == 0) ? 1 : pre;
    b = 8 * p;
    prescale = 16'(pre);
    rxd = 1'b0;
    d = cyc + 1;
    s = d + 4 * p + b * (DW + 1);
    for (int k = d + 1; k <= s; k++) exp_busy[k] = 1'b1;
    if (stop) begin
      del_v[s + 1] = 1'b1;
      del_d[s + 1] = data;
    end else begin
      ferr_a[s + 1] = 1'b1;
    end
    repeat (b) tick;
    for (int i = 0; i < DW; i++) begin
      rxd = data[i];
      repeat (b) tick;
    end
    rxd = stop;
    repeat (b) tick;
    if (extra_low > 0) begin
      rxd = 1'b0;
      repeat (extra_low) tick;
    end
    rxd = 1'b1;
  endtask

  // A short low pulse that must be rejected at the half-bit check.
  task automatic glitch(input int len, input int pre);
    int p, d;
    p = (pre == 0) ? 1 : pre;
    prescale = 16'(pre);
    rxd = 1'b0;
    d = cyc + 1;
    for (int k = d + 1; k <= d + 4 * p; k++) exp_busy[k] = 1'b1;
    repeat (len) tick;
    rxd = 1'b1;
  endtask

  // Model of the AXI output and the compare process.
  bit            chk_en  = 1'b0;
  bit            mv      = 1'b0;
  logic [DW-1:0] md      = '0;
  bit            tr_prev = 1'b0;
  bit            rst_prev = 1'b1;
  bit            e_ovr;
  bit            e_ferr;
  int            ncur;
  logic [DW-1:0] acc_d [$];
  int            acc_c [$];
  int            ovr_cnt  = 0;
  int            ferr_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      ncur = cyc;
      if (ncur >= MAXC - 2) begin
        n_bad++;
        $display("FAIL cycle_budget: got %0d, expected below %0d", ncur, MAXC - 2);
        $fatal(1, "cycle budget exhausted");
      end
      e_ovr  = 1'b0;
      e_ferr = 1'b0;
      if (rst_prev) begin
        mv = 1'b0;
        md = '0;
      end else begin
        e_ferr = ferr_a[ncur];
        if (del_v[ncur]) begin
          e_ovr = mv && !tr_prev;
          mv    = 1'b1;
          md    = del_d[ncur];
        end else if (mv && tr_prev) begin
          mv = 1'b0;
        end
      end
      check("tvalid", 32'(tvalid), 32'(mv));
      check("tdata", 32'(tdata), 32'(md));
      check("rx_busy", 32'(busy), 32'(exp_busy[ncur]));
      check("rx_overrun_error", 32'(ovr), 32'(e_ovr));
      check("rx_frame_error", 32'(ferr), 32'(e_ferr));
      if (tvalid && tready) begin
        acc_d.push_back(tdata);
        acc_c.push_back(ncur);
      end
      if (ovr)  ovr_cnt++;
      if (ferr) ferr_cnt++;
      tr_prev = tready;
      if (rst) begin
        for (int k = ncur + 1; k < MAXC; k++) begin
          exp_busy[k] = 1'b0;
          del_v[k]    = 1'b0;
          ferr_a[k]   = 1'b0;
        end
      end
      rst_prev = rst;
    end
  end

  int d1, d6, d7, dx, n0;

  initial begin
    repeat (3) tick;
    check("reset_tvalid", 32'(tvalid), 32'd0);
    check("reset_tdata", 32'(tdata), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(ovr), 32'd0);
    check("reset_frame_err", 32'(ferr), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (5) tick;

    // Single frame, always ready.
    tready = 1'b1;
    send_frame(8'hA5, 1'b1, 1, 0, d1);
    repeat (20) tick;
    check("t1_accept_count", 32'(acc_d.size()), 32'd1);
    check("t1_accept_data", 32'(acc_d[0]), 32'hA5);
    check("t1_accept_cycle", 32'(acc_c[0]), 32'(d1 + 77));

    // Back-to-back frames with the sink stalled: second word overwrites the first.
    tready = 1'b0;
    n0 = acc_d.size();
    send_frame(8'h3C, 1'b1, 2, 0, dx);
    send_frame(8'hC3, 1'b1, 2, 0, dx);
    repeat (60) tick;
    check("t2_overrun_count", 32'(ovr_cnt), 32'd1);
    check("t2_held_tvalid", 32'(tvalid), 32'd1);
    check("t2_held_tdata", 32'(tdata), 32'hC3);
    tready = 1'b1;
    repeat (5) tick;
    check("t2_accept_count", 32'(acc_d.size()), 32'(n0 + 1));
    check("t2_accept_data", 32'(acc_d[n0]), 32'hC3);

    // Bad stop bit followed by a long break.
    n0 = acc_d.size();
    send_frame(8'h55, 1'b0, 1, 200, dx);
    repeat (20) tick;
    check("t3_frame_err_count", 32'(ferr_cnt), 32'd1);
    check("t3_no_accept", 32'(acc_d.size()), 32'(n0));

    // Glitch shorter than half a bit, then a good frame.
    glitch(8, 4);
    repeat (40) tick;
    n0 = acc_d.size();
    send_frame(8'h81, 1'b1, 4, 0, dx);
    repeat (40) tick;
    check("t4_accept_count", 32'(acc_d.size()), 32'(n0 + 1));
    check("t4_accept_data", 32'(acc_d[n0]), 32'h81);
    check("t4_frame_err_count", 32'(ferr_cnt), 32'd1);

    // Reset pulse during data bit 3, then a clean frame.
    n0 = acc_d.size();
    fork
      send_frame(8'hFF, 1'b1, 1, 0, dx);
      begin
        repeat (34) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t5_reset_tvalid", 32'(tvalid), 32'd0);
        check("t5_reset_tdata", 32'(tdata), 32'd0);
        check("t5_reset_busy", 32'(busy), 32'd0);
      end
    join
    repeat (10) tick;
    check("t5_no_accept", 32'(acc_d.size()), 32'(n0));
    send_frame(8'h0F, 1'b1, 1, 0, dx);
    repeat (20) tick;
    check("t5_accept_count", 32'(acc_d.size()), 32'(n0 + 1));
    check("t5_accept_data", 32'(acc_d[n0]), 32'h0F);

    // Prescale changed mid-frame must not disturb the frame in flight.
    n0 = acc_d.size();
    fork
      send_frame(8'h96, 1'b1, 1, 0, d6);
      begin
        repeat (20) tick;
        prescale = 16'd8;
      end
    join
    repeat (20) tick;
    check("t6_accept_data", 32'(acc_d[n0]), 32'h96);
    check("t6_accept_cycle", 32'(acc_c[n0]), 32'(d6 + 77));

    // Prescale of zero runs at the prescale-one rate.
    n0 = acc_d.size();
    send_frame(8'h3A, 1'b1, 0, 0, d7);
    repeat (20) tick;
    check("t7_accept_data", 32'(acc_d[n0]), 32'h3A);
    check("t7_accept_cycle", 32'(acc_c[n0]), 32'(d7 + 77));
    check("final_overrun_count", 32'(ovr_cnt), 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
